// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit debounce FSM for raw DIP-switch inputs.
// Presents a registered stable vector, a one-cycle change strobe with per-bit mask, and a busy flag.
module switch_debouncer #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 200,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             changed,
    output logic [WIDTH-1:0] changed_mask,
    output logic             busy
);

    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        ST_STABLE,
        ST_COUNTING
    } deb_state_e;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    deb_state_e       state     [WIDTH];
    deb_state_e       state_nxt [WIDTH];
    logic [CW-1:0]    cnt       [WIDTH];
    logic [CW-1:0]    cnt_nxt   [WIDTH];
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] mask_nxt;
    logic             busy_nxt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stable_nxt = sw_stable;
        mask_nxt   = '0;
        busy_nxt   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                ST_STABLE: begin
                    if (sync2[i] != sw_stable[i]) begin
                        cnt_nxt[i]   = CNT_ONE;
                        state_nxt[i] = ST_COUNTING;
                    end
                end
                ST_COUNTING: begin
                    if (sync2[i] == sw_stable[i]) begin
                        // Input bounced back before the window closed: discard the attempt.
                        cnt_nxt[i]   = '0;
                        state_nxt[i] = ST_STABLE;
                    end else if (cnt[i] == CNT_MAX) begin
                        stable_nxt[i] = sync2[i];
                        mask_nxt[i]   = 1'b1;
                        cnt_nxt[i]    = '0;
                        state_nxt[i]  = ST_STABLE;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_nxt[i]   = '0;
                    state_nxt[i] = ST_STABLE;
                end
            endcase
            busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1        <= RESET_VALUE;
            sync2        <= RESET_VALUE;
            sw_stable    <= RESET_VALUE;
            changed      <= 1'b0;
            changed_mask <= '0;
            busy         <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= ST_STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            sync1        <= sw_raw;
            sync2        <= sync1;
            sw_stable    <= stable_nxt;
            changed_mask <= mask_nxt;
            changed      <= |mask_nxt;
            busy         <= busy_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: short-window instance with a strobe scoreboard,
// plus a 200-cycle instance checked for exact latency and glitch rejection.
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_raw;
    logic [3:0] sw_stable;
    logic       changed;
    logic [3:0] changed_mask;
    logic       busy;
    logic [3:0] sw_raw_l;
    logic [3:0] sw_stable_l;
    logic       changed_l;
    logic [3:0] changed_mask_l;
    logic       busy_l;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         edge_n;
        logic [3:0] mask;
        logic [3:0] value;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] exp_stable;

    switch_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'b0000)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_stable(sw_stable),
        .changed(changed), .changed_mask(changed_mask), .busy(busy)
    );

    switch_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(200), .RESET_VALUE(4'b0000)) dut_long (
        .clk(clk), .reset(reset), .sw_raw(sw_raw_l), .sw_stable(sw_stable_l),
        .changed(changed_l), .changed_mask(changed_mask_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    // Called right after driving a new level: capture on the next edge, update 5 edges later.
    task automatic expect_update(input logic [3:0] mask, input logic [3:0] value);
        exp_t e;
        e.edge_n = cyc + 6;
        e.mask   = mask;
        e.value  = value;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() != 0 && exp_q[0].edge_n == cyc) begin
            e = exp_q.pop_front();
            exp_stable = e.value;
            check("strobe", {31'd0, changed}, 32'd1);
            check("strobe_mask", {28'd0, changed_mask}, {28'd0, e.mask});
        end else begin
            check("quiet", {31'd0, changed}, 32'd0);
            check("quiet_mask", {28'd0, changed_mask}, 32'd0);
        end
        check("stable", {28'd0, sw_stable}, {28'd0, exp_stable});
    endtask

    initial begin
        int upd;
        reset      = 1'b0;
        sw_raw     = 4'hF;
        sw_raw_l   = 4'h0;
        exp_stable = 4'h0;

        // Reset held with all switches high: nothing may leak through.
        for (int j = 0; j < 3; j++) begin
            tick();
            check("rst_busy", {31'd0, busy}, 32'd0);
        end

        // Release: sync1 captures 4'hF on the release edge.
        reset = 1'b1;
        expect_update(4'hF, 4'hF);
        for (int j = 0; j < 8; j++) tick();

        reset_all_low: begin
            sw_raw = 4'h0;
            expect_update(4'hF, 4'h0);
            for (int j = 0; j < 8; j++) tick();
        end

        // Single bit with busy window check.
        sw_raw = 4'b0001;
        expect_update(4'b0001, 4'b0001);
        for (int j = 1; j <= 7; j++) begin
            tick();
            check("busy_win", {31'd0, busy}, (j >= 3 && j <= 5) ? 32'd1 : 32'd0);
        end

        // Bounce on bit 2, then hold high.
        sw_raw = 4'b0101; tick();
        sw_raw = 4'b0001; tick();
        sw_raw = 4'b0101; tick();
        sw_raw = 4'b0001; tick();
        sw_raw = 4'b0101;
        expect_update(4'b0100, 4'b0101);
        for (int j = 0; j < 8; j++) tick();

        // Back to zero, then two bits simultaneously.
        sw_raw = 4'b0000;
        expect_update(4'b0101, 4'b0000);
        for (int j = 0; j < 8; j++) tick();
        sw_raw = 4'b1010;
        expect_update(4'b1010, 4'b1010);
        for (int j = 0; j < 8; j++) tick();

        // Reset while bit 0 has counted to 2; the pending update must vanish.
        sw_raw = 4'b1011;
        expect_update(4'b0001, 4'b1011);
        for (int j = 0; j < 4; j++) tick();
        check("midcnt_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        exp_q.delete();
        exp_stable = 4'b0000;
        tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        expect_update(4'b1011, 4'b1011);
        for (int j = 0; j < 8; j++) tick();
        check("queue_drained", exp_q.size(), 32'd0);

        // Long window: 150-edge glitch on bit 1 is rejected.
        sw_raw_l = 4'b0010;
        for (int j = 0; j < 150; j++) begin
            tick();
            check("glitch_stable", {28'd0, sw_stable_l}, 32'd0);
            check("glitch_changed", {31'd0, changed_l}, 32'd0);
        end
        sw_raw_l = 4'b0000;
        for (int j = 0; j < 10; j++) tick();
        check("glitch_stable_end", {28'd0, sw_stable_l}, 32'd0);
        check("glitch_busy_end", {31'd0, busy_l}, 32'd0);

        // Long window: held change updates exactly 201 edges after capture.
        sw_raw_l = 4'b0001;
        upd = cyc + 202;
        for (int j = 0; j < 210; j++) begin
            tick();
            check("long_stable", {28'd0, sw_stable_l}, (cyc >= upd) ? 32'd1 : 32'd0);
            check("long_changed", {31'd0, changed_l}, (cyc == upd) ? 32'd1 : 32'd0);
            if (cyc == upd) check("long_mask", {28'd0, changed_mask_l}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
